// File: rtl/aes_pkg.sv
// Shared AES constants, FSM encoding and GF(2^8) helper for the encipher core.
package aes_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } aes_fsm_e;

    localparam logic [3:0] NK_AES128  = 4'd3;
    localparam logic [3:0] NK_AES256  = 4'd7;
    localparam logic [3:0] NR_AES128  = 4'd10;
    localparam logic [3:0] NR_AES256  = 4'd14;
    localparam logic [7:0] XTIME_POLY = 8'h1b;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (XTIME_POLY & {8{b[7]}});
    endfunction

    function automatic logic nk_supported(input logic [3:0] nk);
        return (nk == NK_AES128) || (nk == NK_AES256);
    endfunction

endpackage

// File: rtl/aes_encipher_core_if.sv
// Block stream interface of the AES encipher core: plaintext in, ciphertext out.
interface aes_encipher_core_if;
    // valid/ready: a block moves on a rising edge where both are high; the
    // valid side holds its data stable and valid asserted until that edge.
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_block;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_block;

    modport slave (
        input  in_valid, in_block, out_ready,
        output in_ready, out_valid, out_block
    );

    modport master (
        output in_valid, in_block, out_ready,
        input  in_ready, out_valid, out_block
    );
endinterface

// File: rtl/aes_round_fn.sv
// Combinational AES round body: SubBytes, ShiftRows, then MixColumns unless final_round.
module aes_round_fn
    import aes_pkg::*;
(
    input  logic [127:0] state_in,
    input  logic         final_round,
    output logic [127:0] state_out
);
    logic [7:0] sb [16];
    logic [7:0] sr [16];
    logic [7:0] mc [16];

    // Byte i sits at bits 127-8i; byte i is row i%4, column i/4.
    for (genvar i = 0; i < 16; i++) begin : g_sbox
        aes_sbox u_sbox (
            .in_byte  (state_in[127-8*i -: 8]),
            .out_byte (sb[i])
        );
    end

    // Row r rotates left by r columns.
    always_comb begin
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                sr[4*c+r] = sb[4*((c+r)%4)+r];
            end
        end
    end

    always_comb begin
        for (int c = 0; c < 4; c++) begin
            mc[4*c+0] = xtime(sr[4*c]) ^ xtime(sr[4*c+1]) ^ sr[4*c+1] ^ sr[4*c+2] ^ sr[4*c+3];
            mc[4*c+1] = sr[4*c] ^ xtime(sr[4*c+1]) ^ xtime(sr[4*c+2]) ^ sr[4*c+2] ^ sr[4*c+3];
            mc[4*c+2] = sr[4*c] ^ sr[4*c+1] ^ xtime(sr[4*c+2]) ^ xtime(sr[4*c+3]) ^ sr[4*c+3];
            mc[4*c+3] = xtime(sr[4*c]) ^ sr[4*c] ^ sr[4*c+1] ^ sr[4*c+2] ^ xtime(sr[4*c+3]);
        end
    end

    always_comb begin
        state_out = '0;
        for (int i = 0; i < 16; i++) begin
            state_out[127-8*i -: 8] = final_round ? sr[i] : mc[i];
        end
    end
endmodule

// File: rtl/aes_sbox.sv
// AES forward S-box, pure lookup.
module aes_sbox (
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);
    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    assign out_byte = SBOX[in_byte];
endmodule

// File: rtl/aes_encipher_core.sv
// Iterative AES-128/256 encipher core, one round per clock, round keys read by Addr.
// Optional AES_ENC_BLKCNT_EN adds a 32-bit count of output handshakes on blk_cnt.
module aes_encipher_core
    import aes_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [3:0]           Nk,
    input  logic                 key_valid,
    output logic [3:0]           Addr,
    input  logic [127:0]         ex_key,
    aes_encipher_core_if.slave   bus,
    output aes_fsm_e             dbg_state
`ifdef AES_ENC_BLKCNT_EN
    ,
    output logic [31:0]          blk_cnt
`endif
);
    aes_fsm_e     fsm_q, fsm_d;
    logic [3:0]   round_q, round_d;
    logic [3:0]   nr_q, nr_d;
    logic [127:0] blk_q, blk_d;
    logic         out_valid_q, out_valid_d;
    logic [127:0] round_out;
    logic         final_round;
    logic         accept;
    logic         handshake;

    assign final_round = (round_q == nr_q);
    assign accept      = bus.in_valid && bus.in_ready;
    assign handshake   = out_valid_q && bus.out_ready;

    aes_round_fn u_round_fn (
        .state_in    (blk_q),
        .final_round (final_round),
        .state_out   (round_out)
    );

    // round_q is held at 0 outside ROUND/DONE so Addr selects key 0 while idle.
    assign Addr          = round_q;
    assign bus.in_ready  = (fsm_q == IDLE) && key_valid && nk_supported(Nk);
    assign bus.out_valid = out_valid_q;
    assign bus.out_block = blk_q;
    assign dbg_state     = fsm_q;

    always_comb begin
        fsm_d       = fsm_q;
        round_d     = round_q;
        nr_d        = nr_q;
        blk_d       = blk_q;
        out_valid_d = out_valid_q;
        unique case (fsm_q)
            IDLE: begin
                if (accept) begin
                    blk_d   = bus.in_block ^ ex_key;
                    round_d = 4'd1;
                    nr_d    = (Nk == NK_AES256) ? NR_AES256 : NR_AES128;
                    fsm_d   = ROUND;
                end
            end
            ROUND: begin
                blk_d   = round_out ^ ex_key;
                round_d = round_q + 4'd1;
                if (final_round) begin
                    fsm_d       = DONE;
                    out_valid_d = 1'b1;
                end
            end
            DONE: begin
                if (handshake) begin
                    fsm_d       = IDLE;
                    out_valid_d = 1'b0;
                    round_d     = 4'd0;
                end
            end
            default: begin
                fsm_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q       <= IDLE;
            round_q     <= 4'd0;
            nr_q        <= 4'd0;
            blk_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            fsm_q       <= fsm_d;
            round_q     <= round_d;
            nr_q        <= nr_d;
            blk_q       <= blk_d;
            out_valid_q <= out_valid_d;
        end
    end

`ifdef AES_ENC_BLKCNT_EN
    logic [31:0] blk_cnt_q, blk_cnt_d;

    assign blk_cnt_d = blk_cnt_q + {31'd0, handshake};
    assign blk_cnt   = blk_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            blk_cnt_q <= 32'd0;
        end else begin
            blk_cnt_q <= blk_cnt_d;
        end
    end
`endif
endmodule
